// File: rtl/exec_muldiv_pkg.sv
// Shared types for the multiply/divide execute unit.
//   muldiv_op_t    : M-extension op, encoded as its funct3
//   muldiv_state_t : sequencing FSM states
//   div_signed()   : true for the signed divide/remainder ops
package exec_muldiv_pkg;

   typedef enum logic [2:0] {
      OP_MUL    = 3'd0,
      OP_MULH   = 3'd1,
      OP_MULHSU = 3'd2,
      OP_MULHU  = 3'd3,
      OP_DIV    = 3'd4,
      OP_DIVU   = 3'd5,
      OP_REM    = 3'd6,
      OP_REMU   = 3'd7
   } muldiv_op_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_MUL,
      ST_DIV,
      ST_SPEC,
      ST_FIX,
      ST_DONE
   } muldiv_state_t;

   function automatic logic div_signed(input muldiv_op_t o);
      return (o == OP_DIV) || (o == OP_REM);
   endfunction

endpackage

// File: rtl/exec_muldiv_div_iter.sv
// Restoring radix-2 divider core, one quotient bit per cycle on unsigned
// magnitudes.
// Ports:
//   clk, rstn            clock, async active-low reset
//   start                load dividend/divisor and begin XLEN iterations
//   kill                 abandon the division in progress
//   dividend, divisor    unsigned operands (sampled on start)
//   quotient, remainder  results, final after the last iteration
//   done                 high during the cycle whose clock edge performs the
//                        final iteration (results are final the next cycle)
module exec_muldiv_div_iter #(
   parameter int unsigned XLEN = 32
) (
   input  logic            clk,
   input  logic            rstn,
   input  logic            start,
   input  logic            kill,
   input  logic [XLEN-1:0] dividend,
   input  logic [XLEN-1:0] divisor,
   output logic [XLEN-1:0] quotient,
   output logic [XLEN-1:0] remainder,
   output logic            done
);

   localparam int unsigned CW = $clog2(XLEN) + 1;

   logic [CW-1:0]   cnt;
   logic [XLEN-1:0] dsr;
   logic [XLEN:0]   r_sh;
   logic [XLEN-1:0] diff;
   logic            fits;

   // The quotient register starts out holding the dividend and shifts it
   // out MSB-first into the partial remainder while quotient bits shift in.
   always_comb begin
      r_sh = {remainder, quotient[XLEN-1]};
      fits = (r_sh >= {1'b0, dsr});
      // Only used when fits: the true difference is below dsr, so it fits.
      diff = r_sh[XLEN-1:0] - dsr;
   end

   assign done = (cnt == CW'(1));

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         cnt       <= '0;
         dsr       <= '0;
         quotient  <= '0;
         remainder <= '0;
      end else if (kill) begin
         cnt <= '0;
      end else if (start) begin
         cnt       <= CW'(XLEN);
         dsr       <= divisor;
         quotient  <= dividend;
         remainder <= '0;
      end else if (cnt != '0) begin
         cnt       <= cnt - CW'(1);
         quotient  <= {quotient[XLEN-2:0], fits};
         remainder <= fits ? diff : r_sh[XLEN-1:0];
      end
   end

endmodule

// File: rtl/exec_muldiv.sv
// Multi-cycle execute unit for the M extension: MUL/MULH/MULHSU/MULHU,
// DIV/DIVU/REM/REMU, with valid/ready handshakes and flush.
// Ports:
//   clk, rstn             clock, async active-low reset
//   in_valid, in_ready    op handshake (in_ready only in IDLE)
//   op, src0, src1, rd_in op code, rs1/rs2 operands, destination tag
//   flush                 kill any op in flight; blocks a same-cycle accept
//   out_valid, out_ready  result handshake
//   result, rd            registered result and destination tag
//   busy                  unit is not IDLE
module exec_muldiv
   import exec_muldiv_pkg::*;
#(
   parameter int unsigned XLEN        = 32,
   parameter int unsigned MUL_LATENCY = 2,
   parameter int unsigned RD_W        = 6
) (
   input  logic            clk,
   input  logic            rstn,
   input  logic            in_valid,
   output logic            in_ready,
   input  muldiv_op_t      op,
   input  logic [XLEN-1:0] src0,
   input  logic [XLEN-1:0] src1,
   input  logic [RD_W-1:0] rd_in,
   input  logic            flush,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] result,
   output logic [RD_W-1:0] rd,
   output logic            busy
);

   localparam int unsigned     MCW       = $clog2(MUL_LATENCY + 1);
   localparam logic [MCW-1:0]  MCNT_LAST = MCW'((MUL_LATENCY > 1) ? (MUL_LATENCY - 2) : 0);
   localparam logic [XLEN-1:0] MOST_NEG  = {1'b1, {(XLEN-1){1'b0}}};

   muldiv_state_t   state, state_d;
   muldiv_op_t      op_q;
   logic [XLEN-1:0] a_q, b_q, mul_q;
   logic [MCW-1:0]  mcnt;

   logic            accept, div_start, res_we;
   logic [XLEN-1:0] res_d;

   // ---------------- multiplier ----------------
   logic              s0_sx, s1_sx;
   logic [2*XLEN-1:0] a_ext, b_ext, prod;
   logic [XLEN-1:0]   mul_sel;

   always_comb begin
      s0_sx   = (op == OP_MULH) || (op == OP_MULHSU);
      s1_sx   = (op == OP_MULH);
      a_ext   = {{XLEN{s0_sx & src0[XLEN-1]}}, src0};
      b_ext   = {{XLEN{s1_sx & src1[XLEN-1]}}, src1};
      prod    = a_ext * b_ext;
      mul_sel = (op == OP_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
   end

   // ---------------- divider operand prep ----------------
   logic            sdiv, special;
   logic [XLEN-1:0] dvd_mag, dvs_mag;
   logic [XLEN-1:0] quo, rem;
   logic            div_done;

   always_comb begin
      sdiv    = div_signed(op);
      dvd_mag = (sdiv && src0[XLEN-1]) ? ('0 - src0) : src0;
      dvs_mag = (sdiv && src1[XLEN-1]) ? ('0 - src1) : src1;
      special = (src1 == '0) || (sdiv && (src0 == MOST_NEG) && (src1 == '1));
   end

   exec_muldiv_div_iter #(.XLEN(XLEN)) u_div (
      .clk       (clk),
      .rstn      (rstn),
      .start     (div_start),
      .kill      (flush),
      .dividend  (dvd_mag),
      .divisor   (dvs_mag),
      .quotient  (quo),
      .remainder (rem),
      .done      (div_done)
   );

   // Special-case and sign-fixed results, from the latched op/operands.
   // op bit 1 separates REM/REMU from DIV/DIVU.
   logic [XLEN-1:0] spec_res, fix_res;

   always_comb begin
      if (b_q == '0) spec_res = op_q[1] ? a_q : '1;
      else           spec_res = op_q[1] ? '0  : a_q;
   end

   always_comb begin
      case (op_q)
         OP_DIV:  fix_res = (a_q[XLEN-1] ^ b_q[XLEN-1]) ? ('0 - quo) : quo;
         OP_REM:  fix_res = a_q[XLEN-1] ? ('0 - rem) : rem;
         OP_REMU: fix_res = rem;
         default: fix_res = quo;
      endcase
   end

   // ---------------- FSM ----------------
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) state <= ST_IDLE;
      else       state <= state_d;
   end

   always_comb begin
      state_d   = state;
      accept    = 1'b0;
      div_start = 1'b0;
      res_we    = 1'b0;
      res_d     = mul_q;
      case (state)
         ST_IDLE: begin
            if (in_valid && !flush) begin
               accept = 1'b1;
               if (!op[2]) begin
                  // Single-cycle latency skips the MUL wait state entirely.
                  if (MUL_LATENCY == 1) begin
                     state_d = ST_DONE;
                     res_we  = 1'b1;
                     res_d   = mul_sel;
                  end else begin
                     state_d = ST_MUL;
                  end
               end else if (special) begin
                  state_d = ST_SPEC;
               end else begin
                  state_d   = ST_DIV;
                  div_start = 1'b1;
               end
            end
         end
         ST_MUL: begin
            if (mcnt == MCNT_LAST) begin
               state_d = ST_DONE;
               res_we  = 1'b1;
               res_d   = mul_q;
            end
         end
         ST_DIV: begin
            if (div_done) state_d = ST_FIX;
         end
         ST_SPEC: begin
            state_d = ST_DONE;
            res_we  = 1'b1;
            res_d   = spec_res;
         end
         ST_FIX: begin
            state_d = ST_DONE;
            res_we  = 1'b1;
            res_d   = fix_res;
         end
         ST_DONE: begin
            if (out_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
      if (flush && (state != ST_IDLE)) begin
         state_d = ST_IDLE;
         res_we  = 1'b0;
      end
   end

   // ---------------- datapath registers ----------------
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         op_q   <= OP_MUL;
         a_q    <= '0;
         b_q    <= '0;
         rd     <= '0;
         mul_q  <= '0;
         mcnt   <= '0;
         result <= '0;
      end else begin
         if (accept) begin
            op_q  <= op;
            a_q   <= src0;
            b_q   <= src1;
            rd    <= rd_in;
            mul_q <= mul_sel;
            mcnt  <= '0;
         end else if (state == ST_MUL) begin
            mcnt <= mcnt + MCW'(1);
         end
         if (res_we) result <= res_d;
      end
   end

   assign in_ready  = (state == ST_IDLE);
   assign busy      = (state != ST_IDLE);
   assign out_valid = (state == ST_DONE);

endmodule
